pipe_ctrl: RTL and testbench

- Central pipeline controller that produces the 2-bit stall codes consumed by the PC register and the if_id, id_ex, ex_me and me_wb pipeline registers.
- Resolves memory waits, multicycle-unit busy, load-use hazards, branch redirects and writeback-stage exceptions into one consistent set of per-stage commands each cycle.
- Sequences trap entry (drain, then redirect) and discards stale fetch responses after a redirect.

---
 rtl/pipe_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Central pipeline stall/flush controller: per-stage 2-bit stall codes, trap
// entry sequencing and stale-fetch discard after a redirect.
module pipe_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_req_pending,
  input  logic             me_req_pending,
  input  logic             ex_busy,
  input  logic             id_load_use,
  input  logic             ex_redirect,
  input  logic             wb_exception_flag,
  output logic [1:0]       pc_stall,
  output logic [1:0]       if_id_stall,
  output logic [1:0]       id_ex_stall,
  output logic [1:0]       ex_me_stall,
  output logic [1:0]       me_wb_stall,
  output logic             trap_redirect,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] NEXT = 2'b00;
  localparam logic [1:0] KEEP = 2'b01;
  localparam logic [1:0] ZERO = 2'b10;

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    TRAP_DRAIN = 2'b01,
    DISCARD    = 2'b10
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       trap_prev;
  logic       trap_c;
  logic [1:0] pc_c;
  logic [1:0] if_id_c;
  logic [1:0] id_ex_c;
  logic [1:0] ex_me_c;
  logic [1:0] me_wb_c;
  logic       any_pending_c;

  assign any_pending_c = me_req_pending | if_req_pending;

  // State register, pulse history and saturating stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      trap_prev <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      trap_prev <= trap_c;
      if ((pc_c != NEXT) && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  // Next-state and per-stage command resolution
  always_comb begin
    state_nxt = state;
    trap_c    = 1'b0;
    pc_c      = NEXT;
    if_id_c   = NEXT;
    id_ex_c   = NEXT;
    ex_me_c   = NEXT;
    me_wb_c   = NEXT;

    unique case (state)
      RUN: begin
        if (wb_exception_flag) begin
          pc_c    = KEEP;
          if_id_c = ZERO;
          id_ex_c = ZERO;
          ex_me_c = ZERO;
          me_wb_c = ZERO;
          if (any_pending_c) begin
            state_nxt = TRAP_DRAIN;
          end else begin
            // Suppress a back-to-back pulse if the flag lingers in WB
            trap_c = ~trap_prev;
          end
        end else if (me_req_pending) begin
          pc_c    = KEEP;
          if_id_c = KEEP;
          id_ex_c = KEEP;
          ex_me_c = KEEP;
          me_wb_c = ZERO;
        end else if (ex_busy) begin
          pc_c    = KEEP;
          if_id_c = KEEP;
          id_ex_c = KEEP;
          ex_me_c = ZERO;
        end else if (id_load_use) begin
          pc_c    = KEEP;
          if_id_c = KEEP;
          id_ex_c = ZERO;
        end else if (ex_redirect) begin
          if_id_c = ZERO;
          id_ex_c = ZERO;
          if (if_req_pending) begin
            state_nxt = DISCARD;
          end
        end else if (if_req_pending) begin
          pc_c    = KEEP;
          if_id_c = ZERO;
        end
      end

      TRAP_DRAIN: begin
        pc_c    = KEEP;
        if_id_c = ZERO;
        id_ex_c = ZERO;
        ex_me_c = ZERO;
        me_wb_c = ZERO;
        if (!any_pending_c) begin
          trap_c    = ~trap_prev;
          state_nxt = RUN;
        end
      end

      DISCARD: begin
        pc_c    = KEEP;
        if_id_c = ZERO;
        if (wb_exception_flag) begin
          id_ex_c = ZERO;
          ex_me_c = ZERO;
          me_wb_c = ZERO;
          if (any_pending_c) begin
            state_nxt = TRAP_DRAIN;
          end else begin
            trap_c    = ~trap_prev;
            state_nxt = RUN;
          end
        end else begin
          if (me_req_pending) begin
            id_ex_c = KEEP;
            ex_me_c = KEEP;
            me_wb_c = ZERO;
          end else if (ex_busy) begin
            id_ex_c = KEEP;
            ex_me_c = ZERO;
          end else if (id_load_use) begin
            id_ex_c = ZERO;
          end
          // Stale response lands this cycle; if_id already bubbled above
          if (!if_req_pending) begin
            state_nxt = RUN;
          end
        end
      end

      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // Everything bubbles while reset is held
  assign pc_stall      = rst_n ? pc_c    : ZERO;
  assign if_id_stall   = rst_n ? if_id_c : ZERO;
  assign id_ex_stall   = rst_n ? id_ex_c : ZERO;
  assign ex_me_stall   = rst_n ? ex_me_c : ZERO;
  assign me_wb_stall   = rst_n ? me_wb_c : ZERO;
  assign trap_redirect = rst_n & trap_c;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (narrow counter to reach saturation).
module tb_pipe_ctrl;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             if_req_pending = 1'b0;
  logic             me_req_pending = 1'b0;
  logic             ex_busy = 1'b0;
  logic             id_load_use = 1'b0;
  logic             ex_redirect = 1'b0;
  logic             wb_exception_flag = 1'b0;
  logic [1:0]       pc_stall, if_id_stall, id_ex_stall, ex_me_stall, me_wb_stall;
  logic             trap_redirect;
  logic [CNT_W-1:0] stall_cnt;
  logic [9:0]       stalls;

  int passed = 0;
  int total  = 0;

  assign stalls = {pc_stall, if_id_stall, id_ex_stall, ex_me_stall, me_wb_stall};

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_pending(if_req_pending), .me_req_pending(me_req_pending),
    .ex_busy(ex_busy), .id_load_use(id_load_use), .ex_redirect(ex_redirect),
    .wb_exception_flag(wb_exception_flag),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_me_stall(ex_me_stall), .me_wb_stall(me_wb_stall),
    .trap_redirect(trap_redirect), .stall_cnt(stall_cnt)
  );

  // Order: if_req, me_req, ex_busy, load_use, redirect, exception
  task automatic set_in(input logic ifp, input logic mep, input logic exb,
                        input logic lu, input logic exr, input logic wbe);
    if_req_pending    = ifp;
    me_req_pending    = mep;
    ex_busy           = exb;
    id_load_use       = lu;
    ex_redirect       = exr;
    wb_exception_flag = wbe;
  endtask

  // Apply inputs just after the next rising edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(0, 1, 0, 0, 0, 1);
    @(negedge clk);
    total++;
    if (stalls !== 10'b10_10_10_10_10)
      $display("FAIL reset_stalls: got %b expected %b", stalls, 10'b10_10_10_10_10);
    else passed++;
    total++;
    if (trap_redirect !== 1'b0 || stall_cnt !== 4'd0)
      $display("FAIL reset_trap_cnt: got trap=%b cnt=%0d expected trap=0 cnt=0", trap_redirect, stall_cnt);
    else passed++;
    set_in(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    total++;
    if (stalls !== 10'b0 || trap_redirect !== 1'b0 || stall_cnt !== 4'd0)
      $display("FAIL reset_release: got stalls=%b trap=%b cnt=%0d expected 0/0/0", stalls, trap_redirect, stall_cnt);
    else passed++;
  endtask

  task automatic test_load_use();
    do_reset();
    next_cycle();
    set_in(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    total++;
    if (stalls !== 10'b01_01_10_00_00 || stall_cnt !== 4'd0)
      $display("FAIL load_use: got stalls=%b cnt=%0d expected 0101100000 cnt=0", stalls, stall_cnt);
    else passed++;
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (stalls !== 10'b0 || stall_cnt !== 4'd1)
      $display("FAIL load_use_after: got stalls=%b cnt=%0d expected 0 cnt=1", stalls, stall_cnt);
    else passed++;
  endtask

  task automatic test_mem_wait();
    do_reset();
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 0, 1, 0, 0);
      @(negedge clk);
      total++;
      if (stalls !== 10'b01_01_01_01_10)
        $display("FAIL mem_wait_c%0d: got %b expected 0101010110", i, stalls);
      else passed++;
      next_cycle();
    end
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (stalls !== 10'b0 || stall_cnt !== 4'd3)
      $display("FAIL mem_wait_cnt: got stalls=%b cnt=%0d expected 0 cnt=3", stalls, stall_cnt);
    else passed++;
  endtask

  task automatic test_ex_busy();
    do_reset();
    next_cycle();
    set_in(1, 0, 1, 1, 1, 0);
    @(negedge clk);
    total++;
    if (stalls !== 10'b01_01_01_10_00)
      $display("FAIL ex_busy: got %b expected 0101011000", stalls);
    else passed++;
    next_cycle();
    set_in(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (stalls !== 10'b01_10_00_00_00)
      $display("FAIL if_wait: got %b expected 0110000000", stalls);
    else passed++;
  endtask

  task automatic test_redirect_discard();
    logic [9:0] exp [5];
    logic       ifp [5];
    exp[0] = 10'b00_10_10_00_00; ifp[0] = 1'b1;
    exp[1] = 10'b01_10_00_00_00; ifp[1] = 1'b1;
    exp[2] = 10'b01_10_00_00_00; ifp[2] = 1'b1;
    exp[3] = 10'b01_10_00_00_00; ifp[3] = 1'b0;
    exp[4] = 10'b00_00_00_00_00; ifp[4] = 1'b0;
    do_reset();
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      set_in(ifp[i], 0, 0, 0, (i == 0), 0);
      @(negedge clk);
      total++;
      if (stalls !== exp[i] || trap_redirect !== 1'b0)
        $display("FAIL discard_c%0d: got %b trap=%b expected %b trap=0", i, stalls, trap_redirect, exp[i]);
      else passed++;
      if (i < 4) next_cycle();
    end
    total++;
    if (stall_cnt !== 4'd3)
      $display("FAIL discard_cnt: got %0d expected 3", stall_cnt);
    else passed++;
  endtask

  task automatic test_discard_mem();
    do_reset();
    next_cycle();
    set_in(1, 0, 0, 0, 1, 0);
    next_cycle();
    set_in(1, 1, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (stalls !== 10'b01_10_01_01_10)
      $display("FAIL discard_mem: got %b expected 0110010110", stalls);
    else passed++;
  endtask

  task automatic test_trap_drain();
    int pulses = 0;
    do_reset();
    next_cycle();
    for (int i = 0; i < 6; i++) begin
      set_in(0, (i < 4), 0, (i == 2), (i == 3), (i == 0));
      @(negedge clk);
      if (trap_redirect === 1'b1) pulses++;
      if (i < 5) begin
        total++;
        if (stalls !== 10'b01_10_10_10_10 || trap_redirect !== (i == 4))
          $display("FAIL trap_drain_c%0d: got %b trap=%b expected 0110101010 trap=%b", i, stalls, trap_redirect, (i == 4));
        else passed++;
      end else begin
        total++;
        if (stalls !== 10'b0 || trap_redirect !== 1'b0)
          $display("FAIL trap_drain_exit: got %b trap=%b expected 0 trap=0", stalls, trap_redirect);
        else passed++;
      end
      next_cycle();
    end
    total++;
    if (pulses !== 1)
      $display("FAIL trap_pulse_count: got %0d expected 1", pulses);
    else passed++;
  endtask

  task automatic test_trap_immediate();
    do_reset();
    next_cycle();
    set_in(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    total++;
    if (stalls !== 10'b01_10_10_10_10 || trap_redirect !== 1'b1)
      $display("FAIL trap_now: got %b trap=%b expected 0110101010 trap=1", stalls, trap_redirect);
    else passed++;
    next_cycle();
    @(negedge clk);
    total++;
    if (trap_redirect !== 1'b0)
      $display("FAIL trap_back_to_back: got trap=%b expected 0", trap_redirect);
    else passed++;
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_saturation();
    do_reset();
    next_cycle();
    for (int i = 0; i < 17; i++) begin
      set_in(0, 0, 1, 0, 0, 0);
      @(negedge clk);
      total++;
      if (stall_cnt !== 4'((i > 15) ? 15 : i))
        $display("FAIL sat_c%0d: got %0d expected %0d", i, stall_cnt, (i > 15) ? 15 : i);
      else passed++;
      next_cycle();
    end
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (stall_cnt !== 4'hF)
      $display("FAIL sat_hold: got %0d expected 15", stall_cnt);
    else passed++;
  endtask

  task automatic test_reset_mid_trap();
    do_reset();
    next_cycle();
    set_in(0, 1, 0, 0, 0, 1);
    next_cycle();
    set_in(0, 1, 0, 0, 0, 0);
    next_cycle();
    #1;
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    total++;
    if (stalls !== 10'b10_10_10_10_10 || trap_redirect !== 1'b0 || stall_cnt !== 4'd0)
      $display("FAIL mid_trap_reset: got %b trap=%b cnt=%0d expected 1010101010 trap=0 cnt=0", stalls, trap_redirect, stall_cnt);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      @(negedge clk);
      total++;
      if (stalls !== 10'b0 || trap_redirect !== 1'b0 || stall_cnt !== 4'd0)
        $display("FAIL mid_trap_after_c%0d: got %b trap=%b cnt=%0d expected 0 trap=0 cnt=0", i, stalls, trap_redirect, stall_cnt);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mem_wait();
    test_ex_busy();
    test_redirect_discard();
    test_discard_mem();
    test_trap_drain();
    test_trap_immediate();
    test_saturation();
    test_reset_mid_trap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
